// File: rtl/hps_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : hps_cmd_bridge
// Description : Command/status bridge between the HPS PIO pair and the
//               coprocessor core. Decodes a start-edge command word from the
//               data_in PIO, issues it on a valid/ready channel, collects the
//               core response and publishes done/busy/error/opcode/result on
//               the data_out PIO.
//               Optional build macro: HPS_CMD_BRIDGE_TIMEOUT_EN enables a
//               response timeout of TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hps_cmd_bridge #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_clk,
  input  logic        reset,
  input  logic [31:0] pio_cmd_in,
  output logic [31:0] pio_status_out,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_opcode,
  output logic [23:0] cmd_operand,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [23:0] rsp_data
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_in_q;
  logic        r_start_prev;
  logic        w_start_edge;
  logic [3:0]  r_opcode;
  logic [3:0]  w_opcode;
  logic [23:0] r_operand;
  logic [23:0] w_operand;
  logic [23:0] r_result;
  logic [23:0] w_result;
  logic        r_done;
  logic        w_done;
  logic        r_error;
  logic        w_error;
  logic        r_busy;
  logic        r_cmd_valid;
  logic        r_rsp_ready;
  logic        w_timeout_hit;
  logic [2:0]  w_unused_rsvd;

  // Capture the PIO word and remember the previous start bit for edge detect.
  // in_q[31] resets high together with start_prev so that a start bit held
  // through reset release never looks like a fresh request.
  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) begin
      r_in_q       <= 32'h8000_0000;
      r_start_prev <= 1'b1;
    end else begin
      r_in_q       <= pio_cmd_in;
      r_start_prev <= r_in_q[31];
    end
  end

  assign w_start_edge  = r_in_q[31] & ~r_start_prev;
  assign w_unused_rsvd = r_in_q[26:24];

`ifdef HPS_CMD_BRIDGE_TIMEOUT_EN
  localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_tmo_cnt;
  logic               w_tmo_active;

  assign w_tmo_active = (r_state == S_ISSUE) || (r_state == S_WAIT_RSP);

  // Outstanding-command age: cleared on ISSUE entry, counts while busy.
  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_IDLE) && (w_state_next == S_ISSUE)) begin
      r_tmo_cnt <= '0;
    end else if (w_tmo_active) begin
      r_tmo_cnt <= r_tmo_cnt + c_CNT_W'(1);
    end
  end

  assign w_timeout_hit = w_tmo_active && (r_tmo_cnt == c_CNT_MAX);
`else
  // Without the timeout the bridge waits forever and error stays 0.
  localparam int c_unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_timeout_hit = 1'b0;
`endif

  // Next-state and next-status decode; a real response beats the timeout.
  always_comb begin
    w_state_next = r_state;
    w_opcode     = r_opcode;
    w_operand    = r_operand;
    w_result     = r_result;
    w_done       = r_done;
    w_error      = r_error;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_opcode     = r_in_q[30:27];
          w_operand    = r_in_q[23:0];
          w_result     = 24'h0;
          w_done       = 1'b0;
          w_error      = 1'b0;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_timeout_hit) begin
          w_result     = 24'h0;
          w_done       = 1'b1;
          w_error      = 1'b1;
          w_state_next = S_DONE;
        end else if (r_cmd_valid && cmd_ready) begin
          w_state_next = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (r_rsp_ready && rsp_valid) begin
          w_result     = rsp_data;
          w_done       = 1'b1;
          w_state_next = S_DONE;
        end else if (w_timeout_hit) begin
          w_result     = 24'h0;
          w_done       = 1'b1;
          w_error      = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!r_in_q[31]) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latched command/status and registered handshake outputs.
  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) begin
      r_opcode    <= 4'h0;
      r_operand   <= 24'h0;
      r_result    <= 24'h0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_rsp_ready <= 1'b0;
    end else begin
      r_opcode    <= w_opcode;
      r_operand   <= w_operand;
      r_result    <= w_result;
      r_done      <= w_done;
      r_error     <= w_error;
      r_busy      <= (w_state_next == S_ISSUE) || (w_state_next == S_WAIT_RSP);
      r_cmd_valid <= (w_state_next == S_ISSUE);
      r_rsp_ready <= (w_state_next == S_WAIT_RSP);
    end
  end

  assign cmd_valid      = r_cmd_valid;
  assign rsp_ready      = r_rsp_ready;
  assign cmd_opcode     = r_opcode;
  assign cmd_operand    = r_operand;
  assign pio_status_out = {r_done, r_busy, r_error, 1'b0, r_opcode, r_result};

endmodule
`default_nettype wire
